// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, digit codes and scan-FSM encoding for the Segment7 encoder/decoder pair.
package seg7_pkg;

    localparam int unsigned SEG_W      = 8;
    localparam int unsigned DIG_W      = 4;
    localparam int unsigned NUM_DIGITS = 3;

    // Bit positions on the segment bus
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Lit-high patterns, bit 0 = segment a
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [DIG_W-1:0] DIGIT_BLANK = 4'hF;
    localparam logic [DIG_W-1:0] DIGIT_BAD   = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT_SEL = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_HOLD     = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic             dp;
        logic [DIG_W-1:0] digit;
    } digit_slot_t;

    function automatic logic is_onehot3(input logic [2:0] s);
        return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the 7-segment encoder table: pattern to BCD digit plus an undecodable flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]       seg,
    output logic [DIG_W-1:0] digit,
    output logic             bad
);

    always_comb begin
        digit = DIGIT_BAD;
        bad   = 1'b1;
        case (seg)
            SEG_0:     begin digit = 4'd0;        bad = 1'b0; end
            SEG_1:     begin digit = 4'd1;        bad = 1'b0; end
            SEG_2:     begin digit = 4'd2;        bad = 1'b0; end
            SEG_3:     begin digit = 4'd3;        bad = 1'b0; end
            SEG_4:     begin digit = 4'd4;        bad = 1'b0; end
            SEG_5:     begin digit = 4'd5;        bad = 1'b0; end
            SEG_6:     begin digit = 4'd6;        bad = 1'b0; end
            SEG_7:     begin digit = 4'd7;        bad = 1'b0; end
            SEG_7_ALT: begin digit = 4'd7;        bad = 1'b0; end
            SEG_8:     begin digit = 4'd8;        bad = 1'b0; end
            SEG_9:     begin digit = 4'd9;        bad = 1'b0; end
            SEG_BLANK: begin digit = DIGIT_BLANK; bad = 1'b0; end
            default:   begin digit = DIGIT_BAD;   bad = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 3-digit 7-segment scan, captures each settled digit and reports whole frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 65536,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             D1,
    input  logic             D2,
    input  logic             D3,
    input  logic [SEG_W-1:0] DOUT,
    output logic [DIG_W-1:0] DIGIT0,
    output logic [DIG_W-1:0] DIGIT1,
    output logic [DIG_W-1:0] DIGIT2,
    output logic [2:0]       DP,
    output logic             FRAME_VALID,
    output logic             BAD_PATTERN,
    output logic             STALE
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = 17;

    logic [2:0]       sel_raw_c;
    logic [SEG_W-1:0] seg_raw_c;
    logic [2:0]       sel_q;
    logic [SEG_W-1:0] seg_q;
    logic             sel_valid_c;

    scan_state_e      state_q, state_d;
    logic [2:0]       lat_sel_q, lat_sel_d;
    logic [SEG_W-1:0] lat_seg_q, lat_seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture_c;

    logic [DIG_W-1:0] dec_digit_c;
    logic             dec_bad_c;

    digit_slot_t      shadow_q [NUM_DIGITS];
    logic [2:0]       mask_q;
    logic             bad_q;
    logic [TO_W-1:0]  tcnt_q;
    logic             timeout_hit_c;

    // Normalise polarity to one-hot select and lit-high segments
    always_comb begin
        sel_raw_c = SEL_ACTIVE_LOW ? ~{D3, D2, D1} : {D3, D2, D1};
        seg_raw_c = SEG_ACTIVE_LOW ? ~DOUT : DOUT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_q <= 3'b000;
            seg_q <= '0;
        end else begin
            sel_q <= sel_raw_c;
            seg_q <= seg_raw_c;
        end
    end

    assign sel_valid_c = is_onehot3(sel_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_WAIT_SEL;
            lat_sel_q <= 3'b000;
            lat_seg_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lat_sel_q <= lat_sel_d;
            lat_seg_q <= lat_seg_d;
            cnt_q     <= cnt_d;
        end
    end

    // Capture fires once the latched strobe/pattern has been seen SETTLE times in a row
    always_comb begin
        state_d   = state_q;
        lat_sel_d = lat_sel_q;
        lat_seg_d = lat_seg_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            ST_WAIT_SEL: begin
                if (sel_valid_c) begin
                    lat_sel_d = sel_q;
                    lat_seg_d = seg_q;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE)) begin
                    capture_c = 1'b1;
                    state_d   = ST_HOLD;
                end else if ((sel_q == lat_sel_q) && (seg_q == lat_seg_q)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (sel_valid_c) begin
                    lat_sel_d = sel_q;
                    lat_seg_d = seg_q;
                    cnt_d     = CNT_W'(1);
                end else begin
                    state_d = ST_WAIT_SEL;
                end
            end
            ST_HOLD: begin
                if (sel_q != lat_sel_q) begin
                    state_d = ST_WAIT_SEL;
                end
            end
            default: state_d = ST_WAIT_SEL;
        endcase
    end

    seg7_pattern_decode u_decode (
        .seg   (lat_seg_q[SEG_G:SEG_A]),
        .digit (dec_digit_c),
        .bad   (dec_bad_c)
    );

    assign timeout_hit_c = !capture_c && (tcnt_q == TO_W'(TIMEOUT - 1));

    // Frame assembly, publication and stall watchdog
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '{dp: 1'b0, digit: DIGIT_BLANK};
            end
            mask_q      <= 3'b000;
            bad_q       <= 1'b0;
            tcnt_q      <= '0;
            DIGIT0      <= DIGIT_BLANK;
            DIGIT1      <= DIGIT_BLANK;
            DIGIT2      <= DIGIT_BLANK;
            DP          <= 3'b000;
            FRAME_VALID <= 1'b0;
            BAD_PATTERN <= 1'b0;
            STALE       <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;

            if (capture_c) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TO_W'(TIMEOUT)) begin
                tcnt_q <= tcnt_q + TO_W'(1);
            end

            if (mask_q == 3'b111) begin
                DIGIT0      <= shadow_q[0].digit;
                DIGIT1      <= shadow_q[1].digit;
                DIGIT2      <= shadow_q[2].digit;
                DP          <= {shadow_q[2].dp, shadow_q[1].dp, shadow_q[0].dp};
                BAD_PATTERN <= bad_q;
                FRAME_VALID <= 1'b1;
                STALE       <= 1'b0;
                mask_q      <= 3'b000;
                bad_q       <= 1'b0;
            end

            if (timeout_hit_c) begin
                STALE  <= 1'b1;
                mask_q <= 3'b000;
                bad_q  <= 1'b0;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    shadow_q[i] <= '{dp: 1'b0, digit: DIGIT_BLANK};
                end
            end else if (capture_c) begin
                mask_q <= mask_q | lat_sel_q;
                bad_q  <= bad_q | dec_bad_c;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (lat_sel_q[i]) begin
                        shadow_q[i] <= '{dp: lat_seg_q[SEG_DP], digit: dec_digit_c};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of full frames plus hand sequences for settle, ghost, timeout and reset.
module tb_seg7_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       D1, D2, D3;
    logic [7:0] DOUT;
    logic [3:0] DIGIT0, DIGIT1, DIGIT2;
    logic [2:0] DP;
    logic       FRAME_VALID, BAD_PATTERN, STALE;

    seg7_scan_decoder #(
        .SETTLE         (SETTLE),
        .TIMEOUT        (TIMEOUT),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .D1          (D1),
        .D2          (D2),
        .D3          (D3),
        .DOUT        (DOUT),
        .DIGIT0      (DIGIT0),
        .DIGIT1      (DIGIT1),
        .DIGIT2      (DIGIT2),
        .DP          (DP),
        .FRAME_VALID (FRAME_VALID),
        .BAD_PATTERN (BAD_PATTERN),
        .STALE       (STALE)
    );

    always #5 CLK = ~CLK;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   fv_count = 0;
    int   fv_cyc = 0;
    int   stale_rise_cyc = -1000;
    logic prev_stale = 1'b0;
    logic stale_before_fv = 1'b0;
    logic stale_at_fv = 1'b0;

    // Event monitor sampled shortly after each rising edge
    always begin
        @(posedge CLK);
        #2;
        cyc++;
        if (FRAME_VALID === 1'b1) begin
            fv_count++;
            fv_cyc          = cyc;
            stale_before_fv = prev_stale;
            stale_at_fv     = STALE;
        end
        if (STALE === 1'b1 && prev_stale === 1'b0) stale_rise_cyc = cyc;
        prev_stale = STALE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    typedef struct {
        logic [7:0] p0, p1, p2;
        logic [3:0] d0, d1, d2;
        logic [2:0] dp;
        logic       bad;
    } frame_vec_t;

    frame_vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // sel is one-hot lit-high; the bench applies active-low encoding on the pins
    task automatic drive(input logic [2:0] sel, input logic [7:0] seg_lit, input int cycles);
        {D3, D2, D1} = ~sel;
        DOUT = ~seg_lit;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic idle(input int cycles);
        drive(3'b000, 8'h00, cycles);
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        drive(3'b001, p0, 8);
        drive(3'b010, p1, 8);
        drive(3'b100, p2, 8);
        idle(3);
    endtask

    task automatic check_outputs(input string tag, input int d0, input int d1, input int d2,
                                 input int dp, input int bad);
        check({tag, "_digit0"}, int'(DIGIT0), d0);
        check({tag, "_digit1"}, int'(DIGIT1), d1);
        check({tag, "_digit2"}, int'(DIGIT2), d2);
        check({tag, "_dp"},     int'(DP), dp);
        check({tag, "_bad"},    int'(BAD_PATTERN), bad);
    endtask

    initial begin
        int fv0;
        int waited;

        vecs[0] = '{8'h06, 8'h5B, 8'h4F, 4'd1, 4'd2, 4'd3, 3'b000, 1'b0};
        vecs[1] = '{8'h3F, 8'h66, 8'h6D, 4'd0, 4'd4, 4'd5, 3'b000, 1'b0};
        vecs[2] = '{8'h7D, 8'h07, 8'h7F, 4'd6, 4'd7, 4'd8, 3'b000, 1'b0};
        vecs[3] = '{8'h06, 8'h49, 8'hCF, 4'd1, 4'hE, 4'd3, 3'b100, 1'b1};
        vecs[4] = '{8'hEF, 8'h00, 8'h27, 4'd9, 4'hF, 4'd7, 3'b001, 1'b0};
        vecs[5] = '{8'h3F, 8'h86, 8'h00, 4'd0, 4'd1, 4'hF, 3'b010, 1'b0};
        vecs[6] = '{8'h6F, 8'h27, 8'h52, 4'd9, 4'd7, 4'hE, 3'b000, 1'b1};

        RESET = 1'b1;
        {D3, D2, D1} = 3'b111;
        DOUT = 8'hFF;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        check_outputs("reset", 15, 15, 15, 0, 0);
        check("reset_fv", int'(FRAME_VALID), 0);
        check("reset_stale", int'(STALE), 0);

        // Full frames, back-to-back Segment7-style scan
        for (int i = 0; i < 7; i++) begin
            fv0 = fv_count;
            send_frame(vecs[i].p0, vecs[i].p1, vecs[i].p2);
            check($sformatf("vec%0d_fv", i), fv_count - fv0, 1);
            check_outputs($sformatf("vec%0d", i), int'(vecs[i].d0), int'(vecs[i].d1),
                          int'(vecs[i].d2), int'(vecs[i].dp), int'(vecs[i].bad));
        end

        // A 3-cycle strobe is too short to capture; a 4-cycle one completes the frame
        fv0 = fv_count;
        drive(3'b001, 8'h06, 8);
        idle(3);
        drive(3'b010, 8'h6D, 3);
        idle(3);
        drive(3'b100, 8'h4F, 8);
        idle(3);
        check("short_strobe_no_fv", fv_count - fv0, 0);
        drive(3'b010, 8'h7D, 4);
        idle(4);
        check("min_strobe_fv", fv_count - fv0, 1);
        check_outputs("min_strobe", 1, 6, 3, 0, 0);

        // Overlapping strobes and a flickering bus must not capture
        fv0 = fv_count;
        drive(3'b101, 8'h5B, 8);
        for (int k = 0; k < 4; k++) begin
            drive(3'b001, (k % 2 == 0) ? 8'h06 : 8'h3F, 2);
        end
        idle(2);
        drive(3'b010, 8'h7F, 8);
        drive(3'b100, 8'h6F, 8);
        idle(3);
        check("ghost_no_fv", fv_count - fv0, 0);
        drive(3'b001, 8'h27, 8);
        idle(3);
        check("ghost_then_clean_fv", fv_count - fv0, 1);
        check_outputs("ghost_clean", 7, 8, 9, 0, 0);
        check("pre_timeout_stale", int'(STALE), 0);

        // Timeout: last capture is one cycle before FRAME_VALID
        fv0 = fv_count;
        waited = 0;
        while (STALE !== 1'b1 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        check("timeout_stale_set", int'(STALE), 1);
        check("timeout_delay", stale_rise_cyc - fv_cyc, int'(TIMEOUT) - 1);
        check("timeout_no_fv", fv_count - fv0, 0);
        check_outputs("timeout_hold", 7, 8, 9, 0, 0);
        send_frame(8'h80, 8'h3F, 8'h40);
        check("recover_fv", fv_count - fv0, 1);
        check("recover_stale_before", int'(stale_before_fv), 1);
        check("recover_stale_with_fv", int'(stale_at_fv), 0);
        check("recover_stale_now", int'(STALE), 0);
        check_outputs("recover", 15, 0, 14, 1, 1);

        // Reset in the middle of a frame discards the partial capture
        waited = 0;
        while (STALE !== 1'b1 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        check("second_timeout_stale", int'(STALE), 1);
        drive(3'b001, 8'h06, 8);
        drive(3'b010, 8'h5B, 8);
        idle(1);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_outputs("midreset", 15, 15, 15, 0, 0);
        check("midreset_stale", int'(STALE), 0);
        check("midreset_fv", int'(FRAME_VALID), 0);
        fv0 = fv_count;
        drive(3'b100, 8'h4F, 8);
        idle(3);
        check("midreset_partial_no_fv", fv_count - fv0, 0);
        drive(3'b001, 8'h66, 8);
        drive(3'b010, 8'h6D, 8);
        idle(3);
        check("midreset_full_fv", fv_count - fv0, 1);
        check_outputs("midreset_full", 4, 5, 3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receiving end of the multiplexed 3-digit 7-segment display interface driven by Segment7.
- Watches the digit strobes D1/D2/D3 and the segment bus DOUT, waits for each strobe to settle, and decodes each segment pattern back to BCD.
- Assembles a full 3-digit frame, reports the captured value, and flags bad patterns and a stalled scan.
- Used as a self-checking monitor in benches and on-board as a loopback checker.

Parameters:
- SETTLE, 4: consecutive cycles a strobe and DOUT must be stable before capture (2..255).
- TIMEOUT, 65536: cycles with no capture before STALE asserts (width 17 bits).
- SEG_ACTIVE_LOW, 1: 1 means a lit segment or DP is 0 on DOUT.
- SEL_ACTIVE_LOW, 1: 1 means an enabled digit strobe is 0.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- D1  in  1  digit-1 strobe (least significant digit).
- D2  in  1  digit-2 strobe.
- D3  in  1  digit-3 strobe (most significant digit).
- DOUT  in  8  segment bus: [0]=a … [6]=g, [7]=dp.
- DIGIT0  out  4  decoded digit 1.
- DIGIT1  out  4  decoded digit 2.
- DIGIT2  out  4  decoded digit 3.
- DP  out  3  decimal point per digit; [0] is digit 1.
- FRAME_VALID  out  1  one-cycle pulse when DIGIT*/DP update.
- BAD_PATTERN  out  1  last frame contained an undecodable pattern.
- STALE  out  1  no capture within TIMEOUT cycles.

Behaviour:
- Reset (sync, RESET=1 at a rising edge):
  - DIGIT0/1/2 = 4'hF, DP = 0, FRAME_VALID = 0, BAD_PATTERN = 0, STALE = 0.
  - FSM goes to WAIT_SEL; frame mask, settle counter and timeout counter clear.
  - Reset mid-frame discards any partial capture.
- Input stage:
  - D1..D3 and DOUT are registered once. Polarity is normalised per parameter to a one-hot select sel[2:0] and lit-high seg[7:0].
  - Every later latency figure counts from this register.
- Strobe validity: a select counts only if exactly one bit is set. Zero or multiple bits set (ghost or overlap) is treated as "no select".
- FSM states:
  - WAIT_SEL: on a valid select, latch sel and seg, set cnt=1, go to SETTLE.
  - SETTLE:
    - If sel and seg are both unchanged, increment cnt.
    - If either changed, go back to WAIT_SEL, or re-latch directly if the new select is valid.
    - When cnt==SETTLE, capture the digit and go to HOLD.
  - HOLD: stay until the select changes (any value), then go to WAIT_SEL. This guarantees at most one capture per strobe pulse.
- Capture, decoding seg[6:0]:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x27=7, 0x7F=8, 0x6F=9.
  - 0x00 = blank, decoded as 4'hF.
  - Any other pattern decodes as 4'hE and sets a frame-local bad flag.
  - seg[7] goes to the DP shadow for that digit.
  - The result is written to that digit's shadow slot and its frame-mask bit is set.
- Frame completion:
  - When the mask reaches 3'b111, in the cycle after the third capture:
    - copy the shadows to DIGIT*/DP;
    - BAD_PATTERN = bad flag;
    - pulse FRAME_VALID for 1 cycle;
    - clear the mask and bad flag.
  - Recapturing a digit already in the mask overwrites its shadow and does not complete a frame. Scan order is free.
  - Outputs hold their values between frames.
- Latency: the capture cycle is SETTLE cycles after the first registered sample of a valid strobe.
- Timeout:
  - The counter increments every cycle and clears on each capture.
  - When it reaches TIMEOUT: STALE=1, the mask and shadows clear, and the counter saturates.
  - STALE clears on the next FRAME_VALID.
  - Outputs retain their last good frame while STALE=1.
- Simultaneous events: if a capture and the timeout terminal count land in the same cycle, the capture wins and the counter clears.

Decomposition:
- Shared package seg7_pkg holds:
  - the 7-seg pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - DIGIT_BLANK=4'hF and DIGIT_BAD=4'hE;
  - the FSM state encoding;
  - bit-index constants SEG_A..SEG_G and SEG_DP.
- The same constants are intended for reuse by the Segment7 encoder.
- One natural sub-module, seg7_pattern_decode: purely combinational, seg[6:0] in, digit[3:0] and bad out. It is the inverse of the encoder table and can be tested exhaustively.

Test Plan:
1. Segment7-style scan, active-low, digits 1/2/3 = 0x06/0x5B/0x4F each held 8 cycles -> one FRAME_VALID; DIGIT0=1, DIGIT1=2, DIGIT2=3; BAD_PATTERN=0.
2. D2 pulse held only 3 cycles (SETTLE=4) -> no capture; no FRAME_VALID until a D2 pulse of 4 or more cycles arrives.
3. D1 and D3 low together, then a DOUT change mid-settle -> neither is captured; a following clean scan of 7,8,9 using 0x27/0x7F/0x6F -> DIGIT0=7, DIGIT1=8, DIGIT2=9.
4. Digit 2 = 0x49 with DOUT[7] lit on digit 3 -> DIGIT1=4'hE, BAD_PATTERN=1, DP=3'b100; the next clean frame gives BAD_PATTERN=0.
5. Strobes stop with TIMEOUT=64 -> STALE=1 exactly 64 cycles after the last capture; DIGIT* keep their last values; a new full frame clears STALE together with the FRAME_VALID pulse.
6. RESET asserted after two of three digits captured -> outputs return to 4'hF and 0; the next frame needs all three digits again before FRAME_VALID.
